imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Boot-time program loader that sits directly upstream of the single-cycle MIPS core's instruction memory.
- Accepts a byte stream over a valid/ready handshake, e.g. from a UART receiver.
- Packs the bytes big-endian into 32-bit instruction words and writes them sequentially into the instruction ROM/RAM write port.
- Holds the CPU in reset with its enable low until the full image is loaded, then releases it.

Parameters:
- DATA_WIDTH, 32, instruction word width; must be a multiple of 8.
- WORD_COUNT, 16, number of words per image; matches PC range 0..60 at step 4.
- ADDR_WIDTH, log2(WORD_COUNT), width of the word address driven to instruction memory.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-low.
- start  in  1  one-cycle pulse that begins a load.
- byte_in  in  8  stream data byte.
- byte_valid  in  1  byte_in is valid this cycle.
- byte_ready  out  1  loader accepts a byte this cycle.
- mem_addr  out  ADDR_WIDTH  word address to instruction memory.
- mem_data  out  DATA_WIDTH  assembled instruction word.
- mem_wren  out  1  instruction memory write strobe.
- cpu_rst  out  1  CPU reset, active-high; asserted while not in DONE.
- cpu_en  out  1  CPU enable; high only in DONE.
- busy  out  1  high in RECV or WRITE.
- done  out  1  high in DONE.
- err  out  1  checksum error flag; only driven when the optional feature is enabled, otherwise tied 0.

Behaviour:
- Reset (rst==0 at clk edge):
  - State = IDLE.
  - byte_ready=0, mem_wren=0, mem_addr=0, mem_data=0, cpu_rst=1, cpu_en=0, busy=0, done=0, err=0.
  - Byte counter and word index = 0.
  - Applies from any state; a load in progress is abandoned, and partially written memory is not cleared.
- States: IDLE, RECV, WRITE, DONE (plus CHK and ERR when the optional feature is enabled).
- IDLE:
  - cpu_rst=1, cpu_en=0, byte_ready=0.
  - start=1 -> RECV with word index=0 and byte count=0.
- RECV:
  - byte_ready=1.
  - A byte is accepted on a cycle where byte_valid & byte_ready.
  - Shift register: word <= {word[DATA_WIDTH-9:0], byte_in}. The first byte received is the MSB.
  - Byte count increments. On acceptance of byte DATA_WIDTH/8 -> WRITE, and the count resets to 0.
  - byte_valid=0 -> hold state; no timeout.
- WRITE:
  - Exactly 1 cycle with mem_wren=1, mem_addr=word index, mem_data=assembled word.
  - byte_ready=0.
  - Next cycle: if word index==WORD_COUNT-1 -> DONE (or CHK when the feature is enabled); otherwise word index+1 -> RECV.
- Write strobe timing:
  - Latency from acceptance of the last byte of a word to mem_wren: 1 cycle.
  - Minimum 5 cycles per word with byte_valid held high.
- DONE:
  - cpu_rst=0, cpu_en=1, done=1, byte_ready=0.
  - Stays in DONE until reset or start.
  - start in DONE -> RECV with the index cleared; cpu_rst reasserts and cpu_en drops in the same cycle the state changes.
- start in RECV/WRITE is ignored; the load is not restarted.
- Bytes presented outside RECV are not consumed because byte_ready=0.
- mem_addr and mem_data are registered and hold their last values outside WRITE. mem_wren is 0 in every state except WRITE.
- busy = (state==RECV) | (state==WRITE).

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Enabled:
  - A running 8-bit XOR of every accepted image byte is kept, cleared on start.
  - After the final WRITE, go to CHK with byte_ready=1 and accept one checksum byte.
  - Match -> DONE.
  - Mismatch -> ERR: err=1, cpu_rst=1, cpu_en=0. Exit ERR only by start (restarts the load, err cleared) or reset.
- Disabled: CHK and ERR do not exist, err is tied 0, and the last WRITE goes directly to DONE.

Test Plan:
- Reset then idle: rst=0 for 2 cycles, then rst=1 with no start -> cpu_rst=1, cpu_en=0, byte_ready=0, mem_wren=0 indefinitely.
- Full load, back-to-back: start, then 64 bytes with word k = 0x20080000+k sent MSB first -> 16 mem_wren pulses at addr 0..15 with matching data, each 1 cycle after its 4th byte. Then done=1, cpu_en=1, cpu_rst=0.
- Throttled stream: byte_valid toggling 1,0,0 per byte -> identical memory writes. No byte is lost or duplicated, and there is no mem_wren during stalls.
- Reset mid-load: assert rst=0 after word 5's second byte, then start a new load -> writes begin again at addr 0 with fresh byte alignment. cpu_rst stays 1 throughout.
- Restart and ignored start: start pulsed during RECV is ignored. start in DONE -> cpu_en falls and cpu_rst rises in the same cycle, and the next write is to addr 0.
- Checksum (IMEM_LOADER_CHECKSUM_EN):
  - Correct XOR byte -> DONE.
  - Wrong byte (correct value ^ 0x01) -> err=1, cpu_en=0.
  - Subsequent start clears err.

Source files
------------

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: packs a big-endian byte stream into words and holds the CPU in reset until the image is written.
// Optional trailing XOR checksum byte is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int WORD_COUNT = 16,
    parameter int ADDR_WIDTH = $clog2(WORD_COUNT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_wren,
    output logic                  cpu_rst,
    output logic                  cpu_en,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int CNT_W = $clog2(BYTES + 1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE, CHK, ERR} state_t;
`else
    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;
`endif

    state_t                state, state_next;
    logic [CNT_W-1:0]      byte_cnt;
    logic [ADDR_WIDTH-1:0] word_idx;
    // Only the bytes already received are kept; the newest byte completes the word on the fly.
    logic [DATA_WIDTH-9:0] shift_q;
    logic [DATA_WIDTH-1:0] next_word;
    logic                  last_byte;
    logic                  last_word;
    logic                  load_start;
    logic                  accept;

    assign next_word = {shift_q, byte_in};
    assign last_byte = (byte_cnt == CNT_W'(BYTES - 1));
    assign last_word = (word_idx == ADDR_WIDTH'(WORD_COUNT - 1));
    assign accept    = (state == RECV) && byte_valid;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] csum;
    assign load_start = start && (state == IDLE || state == DONE || state == ERR);
`else
    assign load_start = start && (state == IDLE || state == DONE);
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        byte_ready = 1'b0;
        mem_wren   = 1'b0;
        cpu_rst    = 1'b1;
        cpu_en     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        err        = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (start) state_next = RECV;
            end
            RECV: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (byte_valid && last_byte) state_next = WRITE;
            end
            WRITE: begin
                mem_wren = 1'b1;
                busy     = 1'b1;
                if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_next = CHK;
`else
                    state_next = DONE;
`endif
                end else begin
                    state_next = RECV;
                end
            end
            DONE: begin
                cpu_rst = 1'b0;
                cpu_en  = 1'b1;
                done    = 1'b1;
                if (start) state_next = RECV;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK: begin
                byte_ready = 1'b1;
                if (byte_valid) state_next = (byte_in == csum) ? DONE : ERR;
            end
            ERR: begin
                err = 1'b1;
                if (start) state_next = RECV;
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            byte_cnt <= '0;
            word_idx <= '0;
            shift_q  <= '0;
            mem_addr <= '0;
            mem_data <= '0;
        end else begin
            if (load_start) begin
                byte_cnt <= '0;
                word_idx <= '0;
            end
            if (accept) begin
                shift_q <= next_word[DATA_WIDTH-9:0];
                if (last_byte) begin
                    byte_cnt <= '0;
                    mem_addr <= word_idx;
                    mem_data <= next_word;
                end else begin
                    byte_cnt <= byte_cnt + CNT_W'(1);
                end
            end
            if (state == WRITE && !last_word) begin
                word_idx <= word_idx + ADDR_WIDTH'(1);
            end
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            csum <= '0;
        end else if (load_start) begin
            csum <= '0;
        end else if (accept) begin
            csum <= csum ^ byte_in;
        end
    end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table-driven control vectors plus a write scoreboard for full image loads.
module tb_imem_loader;

    localparam int DW = 32;
    localparam int WC = 16;
    localparam int AW = 4;

    localparam logic [6:0] ST_IDLE = 7'b0010000;
    localparam logic [6:0] ST_RECV = 7'b1010100;
    localparam logic [6:0] ST_DONE = 7'b0001010;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    byte_in = '0;
    logic          byte_valid = 1'b0;
    logic          byte_ready;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          mem_wren;
    logic          cpu_rst;
    logic          cpu_en;
    logic          busy;
    logic          done;
    logic          err;

    imem_loader #(.DATA_WIDTH(DW), .WORD_COUNT(WC), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_ready(byte_ready),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren),
        .cpu_rst(cpu_rst), .cpu_en(cpu_en), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int failed = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int unsigned   at;
    } wr_t;
    wr_t sb[$];

    int          m_cnt = 0;
    int          m_idx = 0;
    logic [31:0] m_word = '0;
    logic [7:0]  m_csum = '0;
    int          wren_seen = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %h, want %h", name, got, exp);
        end
    endtask

    function automatic logic [6:0] status();
        return {byte_ready, mem_wren, cpu_rst, cpu_en, busy, done, err};
    endfunction

    // Every write strobe must match the oldest expected write, including the exact cycle.
    always @(negedge clk) begin
        wr_t e;
        if (mem_wren === 1'b1) begin
            wren_seen++;
            if (sb.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL unexpected_wren: got addr %0d data %h, want no write", mem_addr, mem_data);
            end else begin
                e = sb.pop_front();
                check("wr_addr", 64'(mem_addr), 64'(e.addr));
                check("wr_data", 64'(mem_data), 64'(e.data));
                check("wr_cycle", 64'(cyc), 64'(e.at));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit image);
        int n = 0;
        byte_in = b;
        byte_valid = 1'b1;
        while (byte_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            tests++;
            failed++;
            $display("FAIL byte_timeout: got byte_ready 0, want 1");
            byte_valid = 1'b0;
            return;
        end
        if (image) begin
            m_word = {m_word[23:0], b};
            m_csum = m_csum ^ b;
            m_cnt++;
            if (m_cnt == 4) begin
                sb.push_back('{AW'(m_idx), m_word, cyc + 1});
                m_cnt = 0;
                m_idx++;
            end
        end
        @(negedge clk);
    endtask

    task automatic stall(input int n);
        byte_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_start();
        m_cnt = 0;
        m_idx = 0;
        m_csum = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_image(input logic [31:0] base, input int gap, input int nwords, input int ignore_at);
        logic [31:0] w;
        for (int k = 0; k < nwords; k++) begin
            w = base + 32'(k);
            for (int b = 0; b < 4; b++) begin
                send_byte(w[31 - 8*b -: 8], 1'b1);
                if (gap > 0) stall(gap);
                if (k == ignore_at && b == 1) begin
                    byte_valid = 1'b0;
                    start = 1'b1;
                    @(negedge clk);
                    start = 1'b0;
                    check("start_ignored_status", 64'(status()), 64'(ST_RECV));
                end
            end
        end
        byte_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        byte_valid = 1'b0;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("done_status", 64'(status()), 64'(ST_DONE));
    endtask

    task automatic finish_image(input logic [7:0] flip);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(m_csum ^ flip, 1'b0);
        byte_valid = 1'b0;
`else
        if (flip != 8'h00) stall(1);
`endif
    endtask

    typedef struct {
        logic       rst;
        logic       start;
        logic       valid;
        logic [7:0] din;
        logic [6:0] exp;
    } vec_t;
    vec_t vt[8];

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1);
    end

    initial begin
        vt[0] = '{1'b0, 1'b0, 1'b1, 8'h11, ST_IDLE};
        vt[1] = '{1'b0, 1'b1, 1'b1, 8'h22, ST_IDLE};
        vt[2] = '{1'b1, 1'b0, 1'b1, 8'h33, ST_IDLE};
        vt[3] = '{1'b1, 1'b0, 1'b0, 8'h44, ST_IDLE};
        vt[4] = '{1'b1, 1'b1, 1'b0, 8'h55, ST_RECV};
        vt[5] = '{1'b1, 1'b0, 1'b0, 8'h66, ST_RECV};
        vt[6] = '{1'b1, 1'b1, 1'b0, 8'h77, ST_RECV};
        vt[7] = '{1'b0, 1'b0, 1'b0, 8'h88, ST_IDLE};

        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rst = vt[i].rst;
            start = vt[i].start;
            byte_valid = vt[i].valid;
            byte_in = vt[i].din;
            @(negedge clk);
            check($sformatf("vec%0d_status", i), 64'(status()), 64'(vt[i].exp));
        end
        check("reset_addr", 64'(mem_addr), 64'd0);
        check("reset_data", 64'(mem_data), 64'd0);
        rst = 1'b1;
        start = 1'b0;
        byte_valid = 1'b0;
        stall(3);
        check("idle_hold_status", 64'(status()), 64'(ST_IDLE));

        // Back-to-back full image
        wren_seen = 0;
        do_start();
        send_image(32'h20080000, 0, WC, -1);
        finish_image(8'h00);
        wait_done();
        check("full_wren_count", 64'(wren_seen), 64'd16);
        check("full_sb_empty", 64'(sb.size()), 64'd0);
        stall(3);
        check("done_hold_status", 64'(status()), 64'(ST_DONE));

        // Restart from DONE, then a throttled stream with an ignored start mid-word
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("restart_status", 64'(status()), 64'(ST_RECV));
        m_cnt = 0;
        m_idx = 0;
        m_csum = '0;
        wren_seen = 0;
        send_image(32'h20080000, 2, WC, 3);
        finish_image(8'h00);
        wait_done();
        check("throttle_wren_count", 64'(wren_seen), 64'd16);
        check("throttle_sb_empty", 64'(sb.size()), 64'd0);

        // Reset after word 5's second byte, then a fresh load
        do_start();
        send_image(32'h13572468, 0, 5, -1);
        send_byte(8'hC1, 1'b1);
        send_byte(8'hC2, 1'b1);
        byte_valid = 1'b0;
        check("midload_cpu_rst", 64'(cpu_rst), 64'd1);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_status", 64'(status()), 64'(ST_IDLE));
        check("midrst_addr", 64'(mem_addr), 64'd0);
        check("midrst_data", 64'(mem_data), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        check("midrst_sb_empty", 64'(sb.size()), 64'd0);
        wren_seen = 0;
        do_start();
        send_image(32'h0BADF000, 0, WC, -1);
        finish_image(8'h00);
        wait_done();
        check("reload_wren_count", 64'(wren_seen), 64'd16);

`ifdef IMEM_LOADER_CHECKSUM_EN
        do_start();
        send_image(32'hA5C30000, 0, WC, -1);
        finish_image(8'h01);
        stall(3);
        check("csum_bad_status", 64'(status()), 64'(7'b0010001));
        do_start();
        check("csum_restart_status", 64'(status()), 64'(ST_RECV));
        send_image(32'hA5C30000, 1, WC, -1);
        finish_image(8'h00);
        wait_done();
`endif

        check("final_sb_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
